ysyx_25040111_lsu: RTL and testbench
====================================

Name: ysyx_25040111_lsu

Overview:
- Memory access unit directly downstream of the LSU arbiter. Accepts one read or one write request at a time on the arbiter-facing interface.
- Reads may be single-beat data loads or multi-beat I-cache line-fill bursts.
- Converts each request to a 32-bit AXI4 master transaction, aligns narrow data to byte lanes, sign/zero-extends load data, and returns per-beat completion pulses.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; fixed at 32, other values unsupported

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- lsu_rvalid  in  1  read request valid; held until final lsu_rready
- lsu_raddr  in  32  read byte address
- lsu_rlen  in  8  burst beats minus 1; ignored unless lsu_burst
- lsu_burst  in  1  INCR burst read (I-cache fill)
- lsu_rmask  in  2  size: 00 byte, 01 half, 10/11 word
- lsu_rsign  in  1  sign-extend narrow load
- lsu_rready  out  1  one-cycle pulse per returned beat
- lsu_rdata  out  32  formatted read data, valid with lsu_rready
- lsu_wvalid  in  1  write request valid
- lsu_waddr  in  32  write byte address
- lsu_wdata  in  32  write data, LSB-justified
- lsu_wmask  in  2  size encoding as lsu_rmask
- lsu_wready  out  1  one-cycle pulse on write response
- lsu_err  out  1  one-cycle pulse, coincident with rready/wready, on any non-OKAY resp or beat-count mismatch
- AXI AR: arvalid out 1, arready in 1, araddr out 32, arlen out 8, arsize out 3, arburst out 2
- AXI R: rvalid in 1, rready out 1, rdata in 32, rresp in 2, rlast in 1
- AXI AW: awvalid out 1, awready in 1, awaddr out 32, awsize out 3
- AXI W: wvalid out 1, wready in 1, wdata out 32, wstrb out 4, wlast out 1 (always 1)
- AXI B: bvalid in 1, bready out 1, bresp in 2

Behaviour:
- States: IDLE, RADDR, RDATA, WREQ, WRESP. Reset: IDLE; every valid/ready/pulse output 0; lsu_rdata 0; capture registers 0. Reset mid-transaction abandons it; outstanding AXI beats are not drained.
- IDLE accepts a request only when lsu_rready and lsu_wready are both 0. This blocks re-acceptance in the completion-pulse cycle.
- If lsu_wvalid and lsu_rvalid are both high in IDLE, the write wins.
- On accept, capture addr, size, sign, len and burst, and align write data.
- Read accept -> RADDR. arvalid=1 starting the next cycle and held until arready.
  - araddr = captured addr.
  - arsize = 2 for burst, else 0/1/2 per mask.
  - arlen = burst ? rlen : 0; arburst = 01 (INCR).
- arvalid & arready -> RDATA; rready=1 throughout RDATA.
- Each R handshake: the next cycle drives lsu_rready=1 and lsu_rdata = formatted beat; the 8-bit beat counter increments.
- Formatting:
  - Shift rdata right by 8*addr[1:0], using the captured start address.
  - Byte/half: take [7:0]/[15:0]; extend with the top bit if rsign, else zeros.
  - Word and burst beats: unmodified.
- RDATA ends at the handshake with rlast=1 -> IDLE. If rlast arrives with beat count != arlen, or beat count exceeds arlen without rlast, lsu_err pulses with that beat and the state returns to IDLE.
- Write accept -> WREQ. awvalid and wvalid both assert the next cycle and each drops independently on its own handshake. These handshakes may occur in either order or in the same cycle.
  - wdata = lsu_wdata << 8*addr[1:0].
  - wstrb = (0001/0011/1111 per mask) << addr[1:0]. Unaligned-overflow bits are dropped; natural alignment is the caller's responsibility.
- Both AW and W complete -> WRESP, bready=1. bvalid -> the next cycle lsu_wready=1 (plus lsu_err if bresp!=00) -> IDLE.
- Minimum latency with zero-wait slave: accept edge -> arvalid (cycle 1) -> R beat (cycle 2) -> lsu_rready (cycle 3).
- An AXI rvalid/bvalid outside RDATA/WRESP is ignored and never acknowledged.

Test Plan:
- Byte load, addr 0x8000_0003, rsign=1, slave rdata 0x80FF_1234 -> lsu_rdata 0xFFFF_FF80, single lsu_rready pulse 3 cycles after accept, arsize 0, arlen 0.
- Half load, addr 0x8000_0002, rsign=0, rdata 0x9ABC_5678 -> 0x0000_9ABC.
- Burst, rlen=3, addr 0x3000_0010, slave inserts 2 wait cycles before beat 2 -> arlen 3, arsize 2, 4 lsu_rready pulses carrying beats unmodified, no re-accept in the cycle of the 4th pulse while lsu_rvalid is still high.
- Half store, addr 0x8000_0006, data 0x0000_BEEF -> wdata 0xBEEF_0000, wstrb 1100. Run with awready 2 cycles before wready and with the reverse order; lsu_wready pulses once after bvalid.
- Simultaneous lsu_rvalid and lsu_wvalid in IDLE -> AW issued first. The read starts only after the lsu_wready pulse; no AR before the B handshake.
- Error and reset cases:
  - rresp=10 on a single load -> lsu_err and lsu_rready pulse together.
  - Burst rlen=3 with rlast on beat 2 -> lsu_err, state returns to IDLE.
  - reset asserted while in RDATA -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/ysyx_25040111_lsu_if.sv
// Bundles for the LSU: arbiter-facing request/response side and the AXI4 master side.
// master modport is the side that issues requests on each bundle.
interface ysyx_25040111_lsu_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic              lsu_rvalid;
  logic [ADDR_W-1:0] lsu_raddr;
  logic [7:0]        lsu_rlen;
  logic              lsu_burst;
  logic [1:0]        lsu_rmask;
  logic              lsu_rsign;
  logic              lsu_rready;
  logic [DATA_W-1:0] lsu_rdata;
  logic              lsu_wvalid;
  logic [ADDR_W-1:0] lsu_waddr;
  logic [DATA_W-1:0] lsu_wdata;
  logic [1:0]        lsu_wmask;
  logic              lsu_wready;
  logic              lsu_err;

  modport master (
    output lsu_rvalid, lsu_raddr, lsu_rlen, lsu_burst, lsu_rmask, lsu_rsign,
           lsu_wvalid, lsu_waddr, lsu_wdata, lsu_wmask,
    input  lsu_rready, lsu_rdata, lsu_wready, lsu_err
  );
  modport slave (
    input  lsu_rvalid, lsu_raddr, lsu_rlen, lsu_burst, lsu_rmask, lsu_rsign,
           lsu_wvalid, lsu_waddr, lsu_wdata, lsu_wmask,
    output lsu_rready, lsu_rdata, lsu_wready, lsu_err
  );
endinterface

interface ysyx_25040111_axi_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic              arvalid, arready;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              rvalid, rready, rlast;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              awvalid, awready;
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awsize;
  logic              wvalid, wready, wlast;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        wstrb;
  logic              bvalid, bready;
  logic [1:0]        bresp;

  modport master (
    output arvalid, araddr, arlen, arsize, arburst, rready,
           awvalid, awaddr, awsize, wvalid, wdata, wstrb, wlast, bready,
    input  arready, rvalid, rdata, rresp, rlast, awready, wready, bvalid, bresp
  );
  modport slave (
    input  arvalid, araddr, arlen, arsize, arburst, rready,
           awvalid, awaddr, awsize, wvalid, wdata, wstrb, wlast, bready,
    output arready, rvalid, rdata, rresp, rlast, awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/ysyx_25040111_lsu.sv
// LSU memory access unit: one outstanding read (single or INCR burst) or write,
// converted to a 32-bit AXI4 transaction with byte-lane alignment and load extension.
module ysyx_25040111_lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clock,
  input  logic                reset,
  ysyx_25040111_lsu_if.slave  lsu,
  ysyx_25040111_axi_if.master axi
);

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WREQ, WRESP} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              sign_q, burst_q;
  logic [7:0]        len_q, beat_cnt;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [3:0]        wstrb_q;
  logic              arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
  logic              lsu_rready_q, lsu_wready_q, err_q;

  function automatic logic [1:0] size_of(input logic [1:0] m);
    return m[1] ? 2'd2 : m;
  endfunction

  function automatic logic [3:0] strb_of(input logic [1:0] m);
    case (m)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Narrow loads use the captured start address; burst beats pass through raw.
  logic [DATA_W-1:0] r_shift, r_fmt;
  always_comb begin
    r_shift = axi.rdata >> {addr_q[1:0], 3'b000};
    r_fmt   = axi.rdata;
    if (!burst_q && size_q == 2'd0)
      r_fmt = {{(DATA_W-8){sign_q & r_shift[7]}}, r_shift[7:0]};
    else if (!burst_q && size_q == 2'd1)
      r_fmt = {{(DATA_W-16){sign_q & r_shift[15]}}, r_shift[15:0]};
  end

  logic last_bad, beat_err;
  assign last_bad = axi.rlast ? (beat_cnt != len_q) : (beat_cnt > len_q);
  assign beat_err = last_bad | (axi.rresp != 2'b00);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      addr_q       <= '0;
      size_q       <= '0;
      sign_q       <= 1'b0;
      burst_q      <= 1'b0;
      len_q        <= '0;
      beat_cnt     <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      wstrb_q      <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      lsu_rready_q <= 1'b0;
      lsu_wready_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      lsu_rready_q <= 1'b0;
      lsu_wready_q <= 1'b0;
      err_q        <= 1'b0;
      case (state)
        // Holding off while a completion pulse is out keeps a still-high
        // request from being taken a second time.
        IDLE: if (!lsu_rready_q && !lsu_wready_q) begin
          if (lsu.lsu_wvalid) begin
            addr_q    <= lsu.lsu_waddr;
            size_q    <= size_of(lsu.lsu_wmask);
            wdata_q   <= lsu.lsu_wdata << {lsu.lsu_waddr[1:0], 3'b000};
            wstrb_q   <= strb_of(lsu.lsu_wmask) << lsu.lsu_waddr[1:0];
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            state     <= WREQ;
          end else if (lsu.lsu_rvalid) begin
            addr_q    <= lsu.lsu_raddr;
            size_q    <= lsu.lsu_burst ? 2'd2 : size_of(lsu.lsu_rmask);
            sign_q    <= lsu.lsu_rsign;
            burst_q   <= lsu.lsu_burst;
            len_q     <= lsu.lsu_burst ? lsu.lsu_rlen : 8'd0;
            beat_cnt  <= '0;
            arvalid_q <= 1'b1;
            state     <= RADDR;
          end
        end
        RADDR: if (axi.arready) begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
          state     <= RDATA;
        end
        RDATA: if (axi.rvalid) begin
          beat_cnt     <= beat_cnt + 8'd1;
          lsu_rready_q <= 1'b1;
          rdata_q      <= r_fmt;
          err_q        <= beat_err;
          if (axi.rlast || last_bad) begin
            rready_q <= 1'b0;
            state    <= IDLE;
          end
        end
        WREQ: begin
          if (axi.awready) awvalid_q <= 1'b0;
          if (axi.wready)  wvalid_q  <= 1'b0;
          if ((!awvalid_q || axi.awready) && (!wvalid_q || axi.wready)) begin
            bready_q <= 1'b1;
            state    <= WRESP;
          end
        end
        WRESP: if (axi.bvalid) begin
          bready_q     <= 1'b0;
          lsu_wready_q <= 1'b1;
          err_q        <= (axi.bresp != 2'b00);
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign axi.arvalid = arvalid_q;
  assign axi.araddr  = addr_q;
  assign axi.arlen   = len_q;
  assign axi.arsize  = {1'b0, size_q};
  assign axi.arburst = 2'b01;
  assign axi.rready  = rready_q;
  assign axi.awvalid = awvalid_q;
  assign axi.awaddr  = addr_q;
  assign axi.awsize  = {1'b0, size_q};
  assign axi.wvalid  = wvalid_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.wlast   = 1'b1;
  assign axi.bready  = bready_q;

  assign lsu.lsu_rready = lsu_rready_q;
  assign lsu.lsu_rdata  = rdata_q;
  assign lsu.lsu_wready = lsu_wready_q;
  assign lsu.lsu_err    = err_q;

endmodule

// File: tb/tb_ysyx_25040111_lsu.sv
// Directed bench for ysyx_25040111_lsu: vector table of single loads/stores
// plus hand-written burst, ordering and reset sequences against a scripted AXI slave.
module tb_ysyx_25040111_lsu;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ysyx_25040111_lsu_if lsu_b ();
  ysyx_25040111_axi_if axi_b ();

  ysyx_25040111_lsu dut (.clock(clock), .reset(reset), .lsu(lsu_b), .axi(axi_b));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  mask;
    bit          sign;
    logic [1:0]  resp;
    int          awd;
    int          wd;
    logic [31:0] exp_data;
    logic [3:0]  exp_strb;
    logic [2:0]  exp_size;
    bit          exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] beat(input int k);
    return {16'hB0B0, 8'(k), 8'h85};
  endfunction

  task automatic idle_inputs();
    lsu_b.lsu_rvalid = 1'b0; lsu_b.lsu_raddr = '0; lsu_b.lsu_rlen = '0;
    lsu_b.lsu_burst = 1'b0; lsu_b.lsu_rmask = '0; lsu_b.lsu_rsign = 1'b0;
    lsu_b.lsu_wvalid = 1'b0; lsu_b.lsu_waddr = '0; lsu_b.lsu_wdata = '0; lsu_b.lsu_wmask = '0;
    axi_b.arready = 1'b0; axi_b.rvalid = 1'b0; axi_b.rdata = '0; axi_b.rresp = '0; axi_b.rlast = 1'b0;
    axi_b.awready = 1'b0; axi_b.wready = 1'b0; axi_b.bvalid = 1'b0; axi_b.bresp = '0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_arvalid"},    32'(axi_b.arvalid), 32'd0);
    chk({tag, "_rready"},     32'(axi_b.rready), 32'd0);
    chk({tag, "_awvalid"},    32'(axi_b.awvalid), 32'd0);
    chk({tag, "_wvalid"},     32'(axi_b.wvalid), 32'd0);
    chk({tag, "_bready"},     32'(axi_b.bready), 32'd0);
    chk({tag, "_lsu_rready"}, 32'(lsu_b.lsu_rready), 32'd0);
    chk({tag, "_lsu_wready"}, 32'(lsu_b.lsu_wready), 32'd0);
    chk({tag, "_lsu_err"},    32'(lsu_b.lsu_err), 32'd0);
    chk({tag, "_lsu_rdata"},  lsu_b.lsu_rdata, 32'd0);
  endtask

  // Single load; the AXI slave holds rvalid from the start so any early acknowledge would show.
  task automatic run_load(input string tag, input vec_t v);
    int pulses = 0, first = 0;
    logic [31:0] got_data = '0;
    logic got_err = 1'b0;
    @(posedge clock); #1;
    lsu_b.lsu_rvalid = 1'b1; lsu_b.lsu_raddr = v.addr; lsu_b.lsu_rmask = v.mask;
    lsu_b.lsu_rsign = v.sign; lsu_b.lsu_burst = 1'b0; lsu_b.lsu_rlen = 8'd5;
    axi_b.arready = 1'b1; axi_b.rvalid = 1'b1; axi_b.rdata = v.data;
    axi_b.rresp = v.resp; axi_b.rlast = 1'b1;
    @(posedge clock);
    for (int n = 1; n <= 6; n++) begin
      @(negedge clock);
      if (n == 1) begin
        chk({tag, "_arvalid"}, 32'(axi_b.arvalid), 32'd1);
        chk({tag, "_araddr"},  axi_b.araddr, v.addr);
        chk({tag, "_arsize"},  32'(axi_b.arsize), 32'(v.exp_size));
        chk({tag, "_arlen"},   32'(axi_b.arlen), 32'd0);
        chk({tag, "_arburst"}, 32'(axi_b.arburst), 32'd1);
      end
      if (lsu_b.lsu_rready) begin
        pulses++;
        if (pulses == 1) begin
          first = n; got_data = lsu_b.lsu_rdata; got_err = lsu_b.lsu_err;
          axi_b.rvalid = 1'b0;
          @(posedge clock); #1;
          lsu_b.lsu_rvalid = 1'b0;
        end
      end
    end
    chk({tag, "_pulses"},    32'(pulses), 32'd1);
    chk({tag, "_latency"},   32'(first), 32'd3);
    chk({tag, "_rdata"},     got_data, v.exp_data);
    chk({tag, "_err"},       32'(got_err), 32'(v.exp_err));
    chk({tag, "_noreissue"}, 32'(axi_b.arvalid), 32'd0);
    axi_b.arready = 1'b0; axi_b.rlast = 1'b0; axi_b.rresp = '0;
  endtask

  task automatic run_store(input string tag, input vec_t v);
    int aw_hs = 0, w_hs = 0, pulses = 0;
    bit early = 1'b0, ar_seen = 1'b0, b_sent = 1'b0;
    logic got_err = 1'b0;
    @(posedge clock); #1;
    lsu_b.lsu_wvalid = 1'b1; lsu_b.lsu_waddr = v.addr; lsu_b.lsu_wdata = v.data; lsu_b.lsu_wmask = v.mask;
    @(posedge clock);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clock);
      if (n == 1) begin
        chk({tag, "_awvalid"}, 32'(axi_b.awvalid), 32'd1);
        chk({tag, "_wvalid"},  32'(axi_b.wvalid), 32'd1);
        chk({tag, "_awaddr"},  axi_b.awaddr, v.addr);
        chk({tag, "_awsize"},  32'(axi_b.awsize), 32'(v.exp_size));
        chk({tag, "_wdata"},   axi_b.wdata, v.exp_data);
        chk({tag, "_wstrb"},   32'(axi_b.wstrb), 32'(v.exp_strb));
        chk({tag, "_wlast"},   32'(axi_b.wlast), 32'd1);
      end
      if (lsu_b.lsu_wready) begin
        pulses++; got_err = lsu_b.lsu_err; lsu_b.lsu_wvalid = 1'b0;
      end
      if (axi_b.arvalid) ar_seen = 1'b1;
      if (axi_b.bready && !(aw_hs == 1 && w_hs == 1)) early = 1'b1;
      axi_b.awready = (n >= 1 + v.awd);
      axi_b.wready  = (n >= 1 + v.wd);
      if (axi_b.awvalid && axi_b.awready) aw_hs++;
      if (axi_b.wvalid && axi_b.wready) w_hs++;
      axi_b.bvalid = axi_b.bready && !b_sent;
      if (axi_b.bvalid) begin b_sent = 1'b1; axi_b.bresp = v.resp; end
    end
    chk({tag, "_aw_hs"},   32'(aw_hs), 32'd1);
    chk({tag, "_w_hs"},    32'(w_hs), 32'd1);
    chk({tag, "_bearly"},  32'(early), 32'd0);
    chk({tag, "_pulses"},  32'(pulses), 32'd1);
    chk({tag, "_err"},     32'(got_err), 32'(v.exp_err));
    chk({tag, "_no_ar"},   32'(ar_seen), 32'd0);
    axi_b.awready = 1'b0; axi_b.wready = 1'b0; axi_b.bvalid = 1'b0; axi_b.bresp = '0;
  endtask

  // rlen=3 burst; beat index 2 is delayed two cycles; rlast on last_idx.
  task automatic run_burst(input string tag, input int last_idx, input bit exp_err);
    int b = 0, w = 0, pulses = 0;
    bit pending = 1'b0, reaccept = 1'b0;
    @(posedge clock); #1;
    lsu_b.lsu_rvalid = 1'b1; lsu_b.lsu_raddr = 32'h3000_0010; lsu_b.lsu_burst = 1'b1;
    lsu_b.lsu_rlen = 8'd3; lsu_b.lsu_rmask = 2'b00; lsu_b.lsu_rsign = 1'b1;
    axi_b.arready = 1'b1; axi_b.rvalid = 1'b0;
    @(posedge clock);
    for (int n = 1; n <= 30; n++) begin
      @(negedge clock);
      if (n == 1) begin
        chk({tag, "_arvalid"}, 32'(axi_b.arvalid), 32'd1);
        chk({tag, "_arlen"},   32'(axi_b.arlen), 32'd3);
        chk({tag, "_arsize"},  32'(axi_b.arsize), 32'd2);
        chk({tag, "_araddr"},  axi_b.araddr, 32'h3000_0010);
      end
      if (pulses == last_idx + 1 && axi_b.arvalid) reaccept = 1'b1;
      if (pending) b++;
      if (lsu_b.lsu_rready) begin
        chk($sformatf("%s_beat%0d", tag, pulses), lsu_b.lsu_rdata, beat(pulses));
        chk($sformatf("%s_err%0d", tag, pulses), 32'(lsu_b.lsu_err),
            32'(exp_err && pulses == last_idx));
        pulses++;
        if (pulses == last_idx + 1) begin
          axi_b.rvalid = 1'b0;
          @(posedge clock); #1;
          lsu_b.lsu_rvalid = 1'b0;
        end
      end
      if (b == 2 && w < 2) begin
        axi_b.rvalid = 1'b0; w++;
      end else if (b <= last_idx) begin
        axi_b.rvalid = 1'b1; axi_b.rdata = beat(b); axi_b.rlast = (b == last_idx); axi_b.rresp = '0;
      end else begin
        axi_b.rvalid = 1'b0; axi_b.rlast = 1'b0;
      end
      pending = axi_b.rvalid && axi_b.rready;
    end
    chk({tag, "_pulses"},   32'(pulses), 32'(last_idx + 1));
    chk({tag, "_reaccept"}, 32'(reaccept), 32'd0);
    axi_b.rvalid = 1'b0; axi_b.rlast = 1'b0; axi_b.arready = 1'b0;
    lsu_b.lsu_burst = 1'b0; lsu_b.lsu_rsign = 1'b0;
  endtask

  task automatic run_both();
    int wpulse = 0, rpulse = 0;
    bit early_ar = 1'b0, b_sent = 1'b0, r_sent = 1'b0;
    logic [31:0] got = '0;
    @(posedge clock); #1;
    lsu_b.lsu_wvalid = 1'b1; lsu_b.lsu_waddr = 32'h8000_0004; lsu_b.lsu_wdata = 32'h0000_00AB; lsu_b.lsu_wmask = 2'b00;
    lsu_b.lsu_rvalid = 1'b1; lsu_b.lsu_raddr = 32'h8000_0008; lsu_b.lsu_rmask = 2'b10; lsu_b.lsu_burst = 1'b0;
    axi_b.awready = 1'b1; axi_b.wready = 1'b1; axi_b.arready = 1'b1;
    @(posedge clock);
    for (int n = 1; n <= 30; n++) begin
      @(negedge clock);
      if (n == 1) begin
        chk("both_awvalid_first", 32'(axi_b.awvalid), 32'd1);
        chk("both_no_ar_first",   32'(axi_b.arvalid), 32'd0);
      end
      if (axi_b.arvalid && wpulse == 0) early_ar = 1'b1;
      if (lsu_b.lsu_wready) begin wpulse++; lsu_b.lsu_wvalid = 1'b0; end
      if (lsu_b.lsu_rready) begin rpulse++; got = lsu_b.lsu_rdata; lsu_b.lsu_rvalid = 1'b0; end
      axi_b.bvalid = axi_b.bready && !b_sent;
      if (axi_b.bvalid) b_sent = 1'b1;
      axi_b.rvalid = axi_b.rready && !r_sent; axi_b.rdata = 32'h1357_9BDF; axi_b.rlast = 1'b1;
      if (axi_b.rvalid) r_sent = 1'b1;
    end
    chk("both_wpulse",   32'(wpulse), 32'd1);
    chk("both_rpulse",   32'(rpulse), 32'd1);
    chk("both_early_ar", 32'(early_ar), 32'd0);
    chk("both_rdata",    got, 32'h1357_9BDF);
    idle_inputs();
  endtask

  task automatic run_reset_mid();
    bit in_rdata = 1'b0;
    @(posedge clock); #1;
    lsu_b.lsu_rvalid = 1'b1; lsu_b.lsu_raddr = 32'h8000_0000; lsu_b.lsu_rmask = 2'b10;
    axi_b.arready = 1'b1; axi_b.rvalid = 1'b0;
    for (int n = 0; n < 10 && !in_rdata; n++) begin
      @(negedge clock);
      in_rdata = axi_b.rready;
    end
    chk("rst_reach_rdata", 32'(in_rdata), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check_all_zero("rst_mid");
    idle_inputs();
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  initial begin
    vecs[0] = '{1'b0, 32'h8000_0003, 32'h80FF_1234, 2'b00, 1'b1, 2'b00, 0, 0, 32'hFFFF_FF80, 4'h0, 3'd0, 1'b0};
    vecs[1] = '{1'b0, 32'h8000_0002, 32'h9ABC_5678, 2'b01, 1'b0, 2'b00, 0, 0, 32'h0000_9ABC, 4'h0, 3'd1, 1'b0};
    vecs[2] = '{1'b0, 32'h8000_0000, 32'hDEAD_BEEF, 2'b10, 1'b1, 2'b00, 0, 0, 32'hDEAD_BEEF, 4'h0, 3'd2, 1'b0};
    vecs[3] = '{1'b0, 32'h8000_0001, 32'h0000_A500, 2'b00, 1'b0, 2'b00, 0, 0, 32'h0000_00A5, 4'h0, 3'd0, 1'b0};
    vecs[4] = '{1'b0, 32'h8000_0000, 32'h1234_F00D, 2'b01, 1'b1, 2'b00, 0, 0, 32'hFFFF_F00D, 4'h0, 3'd1, 1'b0};
    vecs[5] = '{1'b0, 32'h8000_0000, 32'h0000_007F, 2'b00, 1'b1, 2'b10, 0, 0, 32'h0000_007F, 4'h0, 3'd0, 1'b1};
    vecs[6] = '{1'b1, 32'h8000_0006, 32'h0000_BEEF, 2'b01, 1'b0, 2'b00, 0, 2, 32'hBEEF_0000, 4'b1100, 3'd1, 1'b0};
    vecs[7] = '{1'b1, 32'h8000_0006, 32'h0000_BEEF, 2'b01, 1'b0, 2'b00, 2, 0, 32'hBEEF_0000, 4'b1100, 3'd1, 1'b0};
    vecs[8] = '{1'b1, 32'h8000_0005, 32'h0000_005A, 2'b00, 1'b0, 2'b00, 0, 0, 32'h0000_5A00, 4'b0010, 3'd0, 1'b0};
    vecs[9] = '{1'b1, 32'h8000_0000, 32'h1234_5678, 2'b10, 1'b0, 2'b10, 1, 1, 32'h1234_5678, 4'b1111, 3'd2, 1'b1};

    idle_inputs();
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_all_zero("reset");
    chk("reset_araddr", axi_b.araddr, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].wr) run_store($sformatf("v%0d", i), vecs[i]);
      else            run_load($sformatf("v%0d", i), vecs[i]);
    end

    run_burst("burst", 3, 1'b0);
    run_burst("burst_short", 2, 1'b1);
    run_load("after_err", vecs[2]);
    run_both();
    run_reset_mid();
    run_load("after_rst", vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1);
  end
endmodule
